// File: rtl/edge_mask_tx.sv
// Edge-mask frame transmitter: streams a double-buffered 32x32 frame to the
// edge-result collector in step with its data_sel index, swapping banks only on frame boundaries.
module edge_mask_tx #(
    parameter int WORDS = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [4:0]       data_sel,
    output logic [31:0]      edge_mask,
    input  logic             tx_en,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [31:0]      wr_data,
    output logic             wr_ready,
    input  logic             commit,
    output logic             commit_pending,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             sync_err,
    input  logic             err_clr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } commit_state_t;

    commit_state_t state, state_nxt;

    logic [1:0][WORDS-1:0][31:0] bank;
    logic                        active;
    logic                        active_nxt;
    logic [4:0]                  prev_sel;

    logic       at_end;
    logic       swap;
    logic       wr_fire;
    logic [4:0] rd_idx;
    logic [4:0] sel_exp;
    logic       seq_err;

    assign commit_pending = (state == ST_ARMED);
    assign wr_ready       = !commit_pending;

    assign at_end     = (data_sel == 5'd31);
    assign wr_fire    = wr_en && wr_ready;
    // The collector moves to data_sel+1 on this same edge, so prefetch that word.
    assign rd_idx     = data_sel + 5'd1;
    assign sel_exp    = prev_sel + 5'd1;
    assign seq_err    = (data_sel != sel_exp);

    // Commit arm/swap control
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit)
                    state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                // A commit seen in this state is a repeat and is ignored.
                if (at_end) begin
                    swap      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign active_nxt = active ^ swap;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= ST_IDLE;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= active_nxt;
        end
    end

    // Host writes only ever land in the shadow bank.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            bank <= '0;
        else if (wr_fire)
            bank[~active][wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            edge_mask <= '0;
        else
            edge_mask <= tx_en ? bank[active_nxt][rd_idx] : 32'd0;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= at_end;
            if (at_end)
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Sticky index-sequence check; a fresh error outranks a same-cycle clear.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            prev_sel <= 5'd31;
            sync_err <= 1'b0;
        end else begin
            prev_sel <= data_sel;
            if (seq_err)
                sync_err <= 1'b1;
            else if (err_clr)
                sync_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_mask_tx.sv
// Directed bench for edge_mask_tx: a behavioural frame model feeds a scoreboard
// queue per edge, plus directed checks on load/commit, lockout, tx gating, sync and wrap.
module tb_edge_mask_tx;

    localparam int CNT_W = 8;  // narrow counter so the wrap is reachable quickly

    logic             CLK = 1'b0;
    logic             RST_n;
    logic [4:0]       data_sel;
    logic [31:0]      edge_mask;
    logic             tx_en;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             wr_ready;
    logic             commit;
    logic             commit_pending;
    logic             frame_done;
    logic [CNT_W-1:0] frame_cnt;
    logic             sync_err;
    logic             err_clr;

    edge_mask_tx #(.WORDS(32), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_n(RST_n), .data_sel(data_sel), .edge_mask(edge_mask),
        .tx_en(tx_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .commit(commit), .commit_pending(commit_pending),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .sync_err(sync_err),
        .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0]      mb [2][32];
    bit               ma, mp, mdone, merr;
    logic [CNT_W-1:0] mcnt;
    logic [4:0]       mprev;
    logic [31:0]      q [$];
    logic [1023:0]    coll;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < 32; w++)
                mb[b][w] = 32'd0;
        ma = 0; mp = 0; mdone = 0; merr = 0;
        mcnt = '0; mprev = 5'd31;
        q.delete();
    endtask

    // One clock: model the edge, push the expected word, then compare after the edge.
    task automatic cyc();
        logic [4:0]  n, pexp;
        bit          sw, err;
        logic [31:0] e;
        sw = (data_sel == 5'd31) && mp;
        n  = data_sel + 5'd1;
        e  = tx_en ? mb[sw ? !ma : ma][n] : 32'd0;
        q.push_back(e);
        if (wr_en && !mp) mb[!ma][wr_addr] = wr_data;
        if (sw) begin ma = !ma; mp = 0; end
        else if (commit && !mp) mp = 1;
        mdone = (data_sel == 5'd31);
        if (mdone) mcnt = mcnt + 1'b1;
        pexp = mprev + 5'd1;
        err  = (data_sel != pexp);
        merr = err ? 1'b1 : (err_clr ? 1'b0 : merr);
        mprev = data_sel;
        @(posedge CLK); #1;
        chk("edge_mask", edge_mask, q.pop_front());
        chk("commit_pending", 32'(commit_pending), 32'(mp));
        chk("wr_ready", 32'(wr_ready), 32'(!mp));
        chk("frame_done", 32'(frame_done), 32'(mdone));
        chk("frame_cnt", 32'(frame_cnt), 32'(mcnt));
        chk("sync_err", 32'(sync_err), 32'(merr));
        data_sel = data_sel + 5'd1;
        coll[1023 - 32*int'(data_sel) -: 32] = edge_mask;
    endtask

    task automatic run_to(input logic [4:0] sel);
        int i = 0;
        while (data_sel != sel && i < 64) begin cyc(); i++; end
        chk("run_to_bound", 32'(data_sel), 32'(sel));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_edge_mask"}, edge_mask, 32'd0);
        chk({tag, "_pending"}, 32'(commit_pending), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    endtask

    initial begin
        int n;
        RST_n = 1'b0; data_sel = 5'd0; tx_en = 1'b1; wr_en = 1'b0;
        wr_addr = 5'd0; wr_data = 32'd0; commit = 1'b0; err_clr = 1'b0;
        coll = '0;
        mreset();
        #7;
        chk_reset_outputs("rst0");
        @(negedge CLK); RST_n = 1'b1; data_sel = 5'd0;

        // Frame 0 (all zero) while loading shadow words 0xA5000000|k
        for (int k = 0; k < 32; k++) begin
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = 32'hA500_0000 | 32'(k);
            cyc();
        end
        wr_en = 1'b0;
        run_to(5'd5);
        commit = 1'b1; cyc(); commit = 1'b0;
        chk("pending_after_commit", 32'(commit_pending), 32'd1);
        run_to(5'd0);
        for (int k = 0; k < 32; k++) begin
            chk("frame_word", edge_mask, 32'hA500_0000 | 32'(k));
            cyc();
        end
        chk("coll_word0", coll[1023:992], 32'hA500_0000);
        chk("coll_word31", coll[31:0], 32'hA500_001F);

        // Boundary commit with lockout of writes and repeat commit
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1111_0003; cyc(); wr_en = 1'b0;
        run_to(5'd31);
        commit = 1'b1; cyc(); commit = 1'b0;
        chk("boundary_no_swap_word0", edge_mask, 32'hA500_0000);
        n = 0;
        while (commit_pending && n < 40) begin
            wr_en = (n == 3); wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
            commit = (n == 4);
            cyc(); n++;
        end
        wr_en = 1'b0; commit = 1'b0;
        chk("pending_cycles", 32'(n), 32'd32);
        run_to(5'd3);
        chk("lockout_word3", edge_mask, 32'h1111_0003);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_0003; commit = 1'b1;
        cyc(); wr_en = 1'b0; commit = 1'b0;
        chk("old_bank_word4", edge_mask, 32'd0);
        run_to(5'd3);
        chk("new_word3", edge_mask, 32'hCAFE_0003);
        cyc(); cyc();
        chk("new_word5", edge_mask, 32'hA500_0005);

        // tx_en gating for indices 10..12
        run_to(5'd9);
        chk("tx_idx9", edge_mask, 32'hA500_0009);
        for (int k = 9; k <= 12; k++) begin
            tx_en = (k > 11);
            cyc();
            if (k < 12) chk("tx_zero", edge_mask, 32'd0);
            else chk("tx_idx13", edge_mask, 32'hA500_000D);
        end
        tx_en = 1'b1;
        run_to(5'd0); run_to(5'd31); run_to(5'd0);

        // Sync error: skip, clear, and error-beats-clear
        run_to(5'd7); cyc();
        data_sel = 5'd9; cyc();
        chk("sync_set", 32'(sync_err), 32'd1);
        cyc();
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("sync_clr", 32'(sync_err), 32'd0);
        data_sel = data_sel + 5'd2; err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("sync_err_wins", 32'(sync_err), 32'd1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("sync_clr2", 32'(sync_err), 32'd0);

        // Mid-cycle asynchronous reset with a loaded shadow and armed commit
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555_5555; commit = 1'b1;
        cyc(); wr_en = 1'b0; commit = 1'b0;
        data_sel = data_sel + 5'd3; cyc();
        #2; RST_n = 1'b0; #1;
        chk_reset_outputs("rst_mid");
        mreset();
        @(negedge CLK); @(negedge CLK);
        RST_n = 1'b1; data_sel = 5'd0;
        commit = 1'b1; cyc(); commit = 1'b0;
        run_to(5'd0);
        run_to(5'd3);
        chk("shadow_lost_word3", edge_mask, 32'd0);
        cyc(); cyc();
        chk("shadow_lost_word5", edge_mask, 32'd0);

        // Frame counter wrap
        n = 0;
        while (frame_cnt != {CNT_W{1'b1}} && n < 9000) begin cyc(); n++; end
        chk("cnt_reach_max", 32'(frame_cnt), 32'((1 << CNT_W) - 1));
        run_to(5'd31); cyc();
        chk("cnt_wrap", 32'(frame_cnt), 32'd0);
        chk("wrap_done_pulse", 32'(frame_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_mask_tx.md
# edge_mask_tx

Edge-mask frame transmitter. It feeds the 32-bit `edge_mask` input of the edge-result collector, one word per cycle, in lock-step with the collector's free-running 5-bit `data_sel` word index. The host loads a 32-word (1024-bit) frame into a shadow bank and commits it. The block swaps banks only on a frame boundary, so the collector never receives a torn frame.

## Interface
Parameters:
- `WORDS`, 32: words per frame; fixed, and must match the 5-bit `data_sel`.
- `CNT_W`, 16: width of the frame counter.

Ports:
- `CLK`  in  1  sole clock.
- `RST_n`  in  1  asynchronous, active-low reset.
- `data_sel`  in  5  word index from the collector; increments by 1 mod 32 every cycle.
- `edge_mask`  out  32  registered word, valid in the same cycle the collector shows the matching `data_sel`.
- `tx_en`  in  1  when 0, transmit all-zero words.
- `wr_en`  in  1  write strobe into the shadow bank.
- `wr_addr`  in  5  shadow word index.
- `wr_data`  in  32  shadow word data.
- `wr_ready`  out  1  `!commit_pending`; a write with `wr_ready`=0 is dropped.
- `commit`  in  1  single-cycle request to swap banks at the next frame boundary.
- `commit_pending`  out  1  a commit is armed and the swap has not happened yet.
- `frame_done`  out  1  one-cycle pulse in the cycle after each `data_sel`==31 edge.
- `frame_cnt`  out  CNT_W  number of completed frames; wraps to 0.
- `sync_err`  out  1  sticky flag: `data_sel` sequence broken.
- `err_clr`  in  1  clears `sync_err`.

## Operation
Storage:
- Two banks of 32×32 bits, plus an `active` bit; the other bank is the shadow.
- Both banks reset to 0; `active` resets to 0.

Output word:
- Each edge, `n = (data_sel + 1) mod 32` and `edge_mask <= tx_en ? bank[active][n] : 0`.
- The collector advances `data_sel` on the same edge, so the output stays aligned with it.
- Word k of the frame ends up in collector bits [1023-32k : 992-32k].

Host writes and commit:
- A write with `wr_en`=1 and `wr_ready`=1 stores `wr_data` into `bank[!active][wr_addr]`. The active bank is never written.
- `commit` with `commit_pending`=0 sets `commit_pending` on that edge.
- `commit` while `commit_pending`=1 is ignored.
- `wr_en` and `commit` in the same cycle: the write is performed, then pending is set.

Swap, on an edge where `data_sel`==31:
- If `commit_pending` was already 1 before this edge: `active` toggles, word 0 is taken from the new active bank, and `commit_pending` clears.
- A commit arriving in the `data_sel`==31 cycle itself sets pending only; the swap happens on the next frame boundary.
- Frame 0 after reset is a partial frame: word 0 is the reset value 0.

Frame counting: every `data_sel`==31 edge sets `frame_done` to 1 for one cycle and increments `frame_cnt` mod 2^CNT_W.

Sync check:
- `prev_sel` resets to 31.
- On each edge, if `data_sel` != `(prev_sel + 1) mod 32`, `sync_err` is set; `prev_sel <= data_sel`.
- `err_clr` clears `sync_err`; a new error in the same cycle wins over the clear.
- Transmission continues unchanged while `sync_err` is set.

Reset mid-frame: all state returns to reset values immediately (asynchronously). A pending commit is lost and the shadow contents are lost.

## Timing
- Reset values: `edge_mask`=0, `commit_pending`=0, `wr_ready`=1, `frame_done`=0, `frame_cnt`=0, `sync_err`=0.
- `wr_ready` is combinational from `commit_pending`; every other output is registered.
- Latency:
  - write to visible at the output: one commit plus up to one full frame (at most 33 cycles after `commit`);
  - `commit` to `commit_pending`: 1 cycle;
  - swap to `commit_pending` clear: same edge as the word-0 load.
- Throughput: one word per cycle, continuous; there is no stall path.

## Test plan
- Reset: hold `RST_n`=0 mid-cycle → all outputs at the reset values above, asynchronously. Release with `data_sel` starting at 0 → `edge_mask` is 0 for frame 0 and `sync_err` stays 0.
- Load and commit:
  - Write shadow word k = 0xA5000000|k for k=0..31, pulse `commit` at `data_sel`=5.
  - Expect `commit_pending`=1 until the `data_sel`==31 edge.
  - In the next frame, while `data_sel`=k, expect `edge_mask`=0xA5000000|k.
  - A collector model must hold word 0 in bits [1023:992].
- Boundary commit: pulse `commit` exactly when `data_sel`=31 → no swap on that edge; the swap happens 32 cycles later and `commit_pending` stays 1 in between.
- Write lockout: while pending, write `wr_addr`=3 with 0xDEADBEEF → dropped. Issue a second `commit` → ignored. After the swap, write word 3 again and commit → new data appears only after the following boundary.
- `tx_en`=0 for cycles with `data_sel`=10..12 → `edge_mask`=0 for exactly those indices. `frame_done` still pulses once per 32 cycles and `frame_cnt` increments.
- Sync error:
  - Drive `data_sel` 7→9 → `sync_err`=1 on the next cycle.
  - Pulse `err_clr` → 0.
  - Assert `err_clr` on the same cycle as another skip → `sync_err` stays 1.
  - Let `frame_cnt` reach 0xFFFF → it wraps to 0.
